// File: rtl/qtcore_pkg.sv
// Shared scan-sequencer types and defaults: FSM state encoding, default geometry
// and a counter-width helper.
package qtcore_pkg;

    localparam int unsigned DEF_WORD_W    = 32;
    localparam int unsigned DEF_CHAIN_LEN = 256;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Word-wide shift register and bit counter for serialising one host word
// through the scan chain while capturing the chain's returning bits.
module scan_shift_reg
    import qtcore_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] load_data,
    input  logic              serial_in,
    output logic              serial_out,
    output logic [WORD_W-1:0] shreg,
    output logic              last_bit_c
);

    localparam int unsigned BC_W = cnt_width(WORD_W);

    logic [BC_W-1:0] bit_cnt;

    // Load wins over shift; clear only drops the bit position, data is left for inspection.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_data;
            bit_cnt <= BC_W'(WORD_W - 1);
        end else if (shift) begin
            shreg <= {shreg[WORD_W-2:0], serial_in};
            if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    assign serial_out = shreg[WORD_W-1];
    assign last_bit_c = (bit_cnt == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Scan-chain pass sequencer: loads host words, shifts them through the chain,
// returns the captured words, and interlocks the chain against processor runs.
module scan_sequencer
    import qtcore_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              proc_req_i,
    input  logic              wr_valid_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    output logic [WORD_W-1:0] rd_data_o,
    input  logic              rd_ready_i,
    output logic              scan_enable_o,
    output logic              scan_in_o,
    input  logic              scan_out_i,
    output logic              proc_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic              err_o
);

    localparam int unsigned N_WORDS = CHAIN_LEN / WORD_W;
    localparam int unsigned WC_W    = cnt_width(N_WORDS);

    seq_state_e      state;
    seq_state_e      state_next;
    logic [WC_W-1:0] word_cnt;
    logic [WC_W-1:0] word_cnt_next;
    logic            wr_fire;
    logic            abort_hit;
    logic            start_err;
    logic            shift_en;
    logic            last_bit_c;

    // State and word counter register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
        end else begin
            state    <= state_next;
            word_cnt <= word_cnt_next;
        end
    end

    // Next-state logic; abort outranks every other event in the cycle.
    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        wr_fire       = 1'b0;
        abort_hit     = 1'b0;
        if (abort_i && (state != ST_IDLE)) begin
            abort_hit     = 1'b1;
            state_next    = ST_IDLE;
            word_cnt_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i && !proc_req_i) begin
                        state_next    = ST_LOAD;
                        word_cnt_next = '0;
                    end
                end
                ST_LOAD: begin
                    if (wr_valid_i) begin
                        wr_fire    = 1'b1;
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit_c) begin
                        state_next = ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    if (rd_ready_i) begin
                        word_cnt_next = word_cnt + 1'b1;
                        state_next    = (word_cnt == WC_W'(N_WORDS - 1)) ? ST_FINISH : ST_LOAD;
                    end
                end
                ST_FINISH: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign start_err = start_i && ((state != ST_IDLE) || proc_req_i);
    assign shift_en  = (state == ST_SHIFT) && !abort_hit;

    // Registered handshake/status outputs decoded from the upcoming state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ready_o    <= 1'b0;
            rd_valid_o    <= 1'b0;
            scan_enable_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            aborted_o     <= 1'b0;
            err_o         <= 1'b0;
            proc_en_o     <= 1'b0;
        end else begin
            wr_ready_o    <= (state_next == ST_LOAD);
            rd_valid_o    <= (state_next == ST_UNLOAD);
            scan_enable_o <= (state_next == ST_SHIFT);
            busy_o        <= (state_next != ST_IDLE);
            done_o        <= (state_next == ST_FINISH);
            aborted_o     <= abort_hit;
            proc_en_o     <= proc_req_i && (state == ST_IDLE);
            if (start_err) begin
                err_o <= 1'b1;
            end
        end
    end

    scan_shift_reg #(
        .WORD_W(WORD_W)
    ) u_shift (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .clear      (abort_hit),
        .load       (wr_fire),
        .shift      (shift_en),
        .load_data  (wr_data_i),
        .serial_in  (scan_out_i),
        .serial_out (scan_in_o),
        .shreg      (rd_data_o),
        .last_bit_c (last_bit_c)
    );

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer with a 64-bit loopback chain model and
// a word-level reference for what each full pass returns and leaves behind.
module tb_scan_sequencer;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CHAIN_LEN = 64;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_n = 1'b1;
    logic              start_i;
    logic              abort_i;
    logic              proc_req_i;
    logic              wr_valid_i;
    logic [WORD_W-1:0] wr_data_i;
    logic              wr_ready_o;
    logic              rd_valid_o;
    logic [WORD_W-1:0] rd_data_o;
    logic              rd_ready_i;
    logic              scan_enable_o;
    logic              scan_in_o;
    logic              scan_out_i;
    logic              proc_en_o;
    logic              busy_o;
    logic              done_o;
    logic              aborted_o;
    logic              err_o;

    int errors = 0;
    int checks = 0;

    scan_sequencer #(
        .WORD_W(WORD_W),
        .CHAIN_LEN(CHAIN_LEN)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_n      (wb_rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .proc_req_i    (proc_req_i),
        .wr_valid_i    (wr_valid_i),
        .wr_data_i     (wr_data_i),
        .wr_ready_o    (wr_ready_o),
        .rd_valid_o    (rd_valid_o),
        .rd_data_o     (rd_data_o),
        .rd_ready_i    (rd_ready_i),
        .scan_enable_o (scan_enable_o),
        .scan_in_o     (scan_in_o),
        .scan_out_i    (scan_out_i),
        .proc_en_o     (proc_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .aborted_o     (aborted_o),
        .err_o         (err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Loopback chain: shifts in scan_in_o on every enabled edge, MSB feeds back.
    logic [CHAIN_LEN-1:0] chain;
    logic [CHAIN_LEN-1:0] pre_val;
    logic                 pre_load = 1'b0;
    always @(posedge wb_clk_i) begin
        if (pre_load) chain <= pre_val;
        else if (scan_enable_o) chain <= {chain[CHAIN_LEN-2:0], scan_in_o};
    end
    assign scan_out_i = chain[CHAIN_LEN-1];

    // Event counters observed over the whole run.
    int done_cnt = 0, abort_cnt = 0, overlap_cnt = 0, pe_busy_cnt = 0;
    always @(negedge wb_clk_i) begin
        if (done_o) done_cnt++;
        if (aborted_o) abort_cnt++;
        if (proc_en_o && scan_enable_o) overlap_cnt++;
        if (proc_en_o && busy_o) pe_busy_cnt++;
    end

    // Reference: word k read back is the k-th word of the chain contents from the top.
    function automatic logic [WORD_W-1:0] exp_word(input logic [CHAIN_LEN-1:0] pre, input int k);
        return pre[CHAIN_LEN-1-WORD_W*k -: WORD_W];
    endfunction

    task automatic tick();
        @(negedge wb_clk_i);
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; abort_i = 1'b0; proc_req_i = 1'b0;
        wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        wb_rst_n = 1'b0;
        tick(); tick();
        wb_rst_n = 1'b1;
        tick();
    endtask

    task automatic preload(input logic [CHAIN_LEN-1:0] v);
        pre_val = v; pre_load = 1'b1;
        tick();
        pre_load = 1'b0;
    endtask

    // Drives one two-word pass and reports what it observed.
    task automatic run_pass(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                            input int rd_wait, input logic req_mid,
                            output logic [WORD_W-1:0] r0, output logic [WORD_W-1:0] r1,
                            output int en0, output int en1, output int unload_bad,
                            output int timeouts, output logic done_seen);
        logic [1:0][WORD_W-1:0] wr;
        logic [1:0][WORD_W-1:0] rd;
        int en [2];
        int n;
        logic [WORD_W-1:0] held;
        wr[0] = w0; wr[1] = w1;
        unload_bad = 0; timeouts = 0;
        start_i = 1'b1; tick(); start_i = 1'b0;
        if (req_mid) proc_req_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wr_valid_i = 1'b1; wr_data_i = wr[k]; n = 0;
            while (!wr_ready_o && n < 100) begin tick(); n++; end
            if (!wr_ready_o) timeouts++;
            tick(); wr_valid_i = 1'b0;
            en[k] = 0; n = 0;
            while (!rd_valid_o && n < 200) begin
                if (scan_enable_o) en[k]++;
                tick(); n++;
            end
            if (!rd_valid_o) timeouts++;
            held = rd_data_o;
            for (int d = 0; d < rd_wait; d++) begin
                if (scan_enable_o || !rd_valid_o || rd_data_o !== held) unload_bad++;
                tick();
            end
            if (rd_data_o !== held) unload_bad++;
            rd[k] = rd_data_o;
            rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
        end
        done_seen = done_o;
        r0 = rd[0]; r1 = rd[1]; en0 = en[0]; en1 = en[1];
    endtask

    task automatic test_reset();
        #1 wb_rst_n = 1'b0;
        #1;
        checks++; if ({busy_o, done_o, aborted_o, err_o} !== 4'b0) begin errors++; $display("FAIL reset_status got=%b exp=0000", {busy_o, done_o, aborted_o, err_o}); end
        checks++; if ({wr_ready_o, rd_valid_o} !== 2'b0) begin errors++; $display("FAIL reset_handshake got=%b exp=00", {wr_ready_o, rd_valid_o}); end
        checks++; if ({scan_enable_o, scan_in_o, proc_en_o} !== 3'b0) begin errors++; $display("FAIL reset_scan got=%b exp=000", {scan_enable_o, scan_in_o, proc_en_o}); end
        checks++; if (rd_data_o !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data_o); end
        tick(); tick();
        wb_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_pass();
        logic [WORD_W-1:0] r0, r1; int en0, en1, bad, to; logic ds; int d0;
        preload(64'hA5A5A5A5_5A5A5A5A);
        d0 = done_cnt;
        run_pass(32'h12345678, 32'h9ABCDEF0, 10, 1'b0, r0, r1, en0, en1, bad, to, ds);
        checks++; if (ds !== 1'b1) begin errors++; $display("FAIL full_done got=%b exp=1", ds); end
        tick(); tick();
        checks++; if (to !== 0) begin errors++; $display("FAIL full_timeout got=%0d exp=0", to); end
        checks++; if (r0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL full_rd0 got=%h exp=a5a5a5a5", r0); end
        checks++; if (r1 !== 32'h5A5A5A5A) begin errors++; $display("FAIL full_rd1 got=%h exp=5a5a5a5a", r1); end
        checks++; if (chain !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL full_chain got=%h exp=123456789abcdef0", chain); end
        checks++; if (en0 !== 32 || en1 !== 32) begin errors++; $display("FAIL full_enable_len got=%0d,%0d exp=32,32", en0, en1); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_unload_wait got=%0d bad cycles exp=0", bad); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_busy_after got=%b exp=0", busy_o); end
    endtask

    task automatic test_random_passes();
        logic [CHAIN_LEN-1:0] pre; logic [WORD_W-1:0] w0, w1, r0, r1;
        int en0, en1, bad, to; logic ds;
        for (int it = 0; it < 4; it++) begin
            pre = {$urandom, $urandom}; w0 = $urandom; w1 = $urandom;
            preload(pre);
            run_pass(w0, w1, int'($urandom_range(0, 4)), 1'b0, r0, r1, en0, en1, bad, to, ds);
            tick();
            checks++; if (r0 !== exp_word(pre, 0) || r1 !== exp_word(pre, 1)) begin errors++; $display("FAIL rand_rd[%0d] got=%h_%h exp=%h", it, r0, r1, pre); end
            checks++; if (chain !== {w0, w1}) begin errors++; $display("FAIL rand_chain[%0d] got=%h exp=%h", it, chain, {w0, w1}); end
            checks++; if (en0 + en1 !== 2 * WORD_W || bad !== 0 || to !== 0 || ds !== 1'b1) begin errors++; $display("FAIL rand_timing[%0d] got=en %0d/%0d bad %0d to %0d done %b exp=32/32 0 0 1", it, en0, en1, bad, to, ds); end
        end
    endtask

    task automatic test_interlock();
        logic [CHAIN_LEN-1:0] pre; logic [WORD_W-1:0] w0, w1, r0, r1;
        int en0, en1, bad, to, n, pb; logic ds;
        do_reset();
        proc_req_i = 1'b1;
        checks++; if (proc_en_o !== 1'b0) begin errors++; $display("FAIL ilk_pe_early got=%b exp=0", proc_en_o); end
        tick();
        checks++; if (proc_en_o !== 1'b1) begin errors++; $display("FAIL ilk_pe_latency got=%b exp=1", proc_en_o); end
        start_i = 1'b1; tick(); start_i = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ilk_err got=%b exp=1", err_o); end
        tick();
        checks++; if (busy_o !== 1'b0 || wr_ready_o !== 1'b0) begin errors++; $display("FAIL ilk_stay_idle got=busy %b wr_ready %b exp=0 0", busy_o, wr_ready_o); end
        proc_req_i = 1'b0; tick(); tick();
        checks++; if (proc_en_o !== 1'b0 || err_o !== 1'b1) begin errors++; $display("FAIL ilk_drop got=pe %b err %b exp=0 1", proc_en_o, err_o); end

        do_reset();
        proc_req_i = 1'b1; start_i = 1'b1; tick(); start_i = 1'b0;
        checks++; if ({err_o, busy_o, proc_en_o} !== 3'b101) begin errors++; $display("FAIL ilk_same_cycle got=%b exp=101", {err_o, busy_o, proc_en_o}); end
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ilk_same_cycle_idle got=%b exp=0", busy_o); end

        do_reset();
        pre = {$urandom, $urandom}; w0 = $urandom; w1 = $urandom;
        preload(pre);
        pb = pe_busy_cnt;
        run_pass(w0, w1, 2, 1'b1, r0, r1, en0, en1, bad, to, ds);
        checks++; if (ds !== 1'b1 || proc_en_o !== 1'b0) begin errors++; $display("FAIL ilk_mid_at_done got=done %b pe %b exp=1 0", ds, proc_en_o); end
        n = 0;
        while (!proc_en_o && n < 5) begin tick(); n++; end
        checks++; if (proc_en_o !== 1'b1 || n !== 2) begin errors++; $display("FAIL ilk_mid_release got=pe %b after %0d cycles exp=1 after 2", proc_en_o, n); end
        checks++; if (pe_busy_cnt !== pb || err_o !== 1'b0) begin errors++; $display("FAIL ilk_mid_overlap got=%0d busy cycles err %b exp=0 0", pe_busy_cnt - pb, err_o); end
        checks++; if (r0 !== exp_word(pre, 0) || r1 !== exp_word(pre, 1) || chain !== {w0, w1}) begin errors++; $display("FAIL ilk_mid_data got=%h_%h exp=%h", r0, r1, pre); end
        proc_req_i = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [CHAIN_LEN-1:0] pre; logic [WORD_W-1:0] w0, w1, r0, r1;
        int en0, en1, bad, to, n, d0, a0; logic ds;
        do_reset();
        preload({$urandom, $urandom});
        d0 = done_cnt; a0 = abort_cnt;
        start_i = 1'b1; tick(); start_i = 1'b0;
        wr_valid_i = 1'b1; wr_data_i = $urandom; tick(); wr_valid_i = 1'b0;
        n = 0;
        while (n < 17 && scan_enable_o) begin tick(); n++; end
        checks++; if (n !== 17 || scan_enable_o !== 1'b1) begin errors++; $display("FAIL abort_setup got=%0d shifts en %b exp=17 1", n, scan_enable_o); end
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        checks++; if ({scan_enable_o, aborted_o, busy_o, rd_valid_o} !== 4'b0100) begin errors++; $display("FAIL abort_next got=%b exp=0100", {scan_enable_o, aborted_o, busy_o, rd_valid_o}); end
        tick();
        checks++; if (aborted_o !== 1'b0) begin errors++; $display("FAIL abort_pulse got=%b exp=0", aborted_o); end
        repeat (40) tick();
        checks++; if (done_cnt !== d0 || abort_cnt - a0 !== 1) begin errors++; $display("FAIL abort_counts got=done %0d aborted %0d exp=0 1", done_cnt - d0, abort_cnt - a0); end
        pre = {$urandom, $urandom}; w0 = $urandom; w1 = $urandom;
        preload(pre);
        run_pass(w0, w1, 1, 1'b0, r0, r1, en0, en1, bad, to, ds);
        tick();
        checks++; if (r0 !== exp_word(pre, 0) || r1 !== exp_word(pre, 1) || chain !== {w0, w1} || to !== 0 || ds !== 1'b1) begin errors++; $display("FAIL abort_recover got=%h_%h to %0d done %b exp=%h 0 1", r0, r1, to, ds, pre); end
    endtask

    task automatic test_reset_mid();
        logic [CHAIN_LEN-1:0] pre; logic [WORD_W-1:0] w0, w1, r0, r1;
        int en0, en1, bad, to, d0, a0; logic ds;
        do_reset();
        preload({$urandom, $urandom});
        d0 = done_cnt; a0 = abort_cnt;
        start_i = 1'b1; tick(); start_i = 1'b0;
        wr_valid_i = 1'b1; wr_data_i = $urandom; tick(); wr_valid_i = 1'b0;
        repeat (5) tick();
        checks++; if (scan_enable_o !== 1'b1) begin errors++; $display("FAIL rstmid_setup got=%b exp=1", scan_enable_o); end
        wb_rst_n = 1'b0;
        #1;
        checks++; if ({busy_o, done_o, aborted_o, err_o, wr_ready_o, rd_valid_o, scan_enable_o, scan_in_o, proc_en_o} !== 9'b0 || rd_data_o !== '0) begin errors++; $display("FAIL rstmid_outputs got=%b data %h exp=0 0", {busy_o, done_o, aborted_o, err_o, wr_ready_o, rd_valid_o, scan_enable_o, scan_in_o, proc_en_o}, rd_data_o); end
        tick(); tick();
        wb_rst_n = 1'b1;
        tick();
        checks++; if (done_cnt !== d0 || abort_cnt !== a0) begin errors++; $display("FAIL rstmid_no_pulse got=done %0d aborted %0d exp=0 0", done_cnt - d0, abort_cnt - a0); end
        pre = {$urandom, $urandom}; w0 = $urandom; w1 = $urandom;
        preload(pre);
        run_pass(w0, w1, 3, 1'b0, r0, r1, en0, en1, bad, to, ds);
        tick();
        checks++; if (r0 !== exp_word(pre, 0) || r1 !== exp_word(pre, 1) || chain !== {w0, w1}) begin errors++; $display("FAIL rstmid_clean_data got=%h_%h exp=%h", r0, r1, pre); end
        checks++; if (en0 !== 32 || en1 !== 32 || bad !== 0 || to !== 0 || ds !== 1'b1) begin errors++; $display("FAIL rstmid_clean_timing got=en %0d/%0d bad %0d to %0d done %b exp=32/32 0 0 1", en0, en1, bad, to, ds); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_full_pass();
        test_random_passes();
        test_interlock();
        test_abort();
        test_reset_mid();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL proc_scan_overlap got=%0d cycles exp=0", overlap_cnt); end
        checks++; if (pe_busy_cnt !== 0) begin errors++; $display("FAIL proc_en_while_busy got=%0d cycles exp=0", pe_busy_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning bits per host word.
REQ-002 SHALL have parameter CHAIN_LEN, default 256, meaning total scan-chain bits; legal values are integer multiples of WORD_W and >= WORD_W.
REQ-003 SHALL have port wb_clk_i  in  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_n  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port start_i  in  1  meaning a one-cycle request to begin a full chain pass.
REQ-006 SHALL have port abort_i  in  1  meaning terminate the pass in progress.
REQ-007 SHALL have port proc_req_i  in  1  meaning the host wants the processor running.
REQ-008 SHALL have ports wr_valid_i  in  1, wr_data_i  in  WORD_W, and wr_ready_o  out  1, meaning the host-to-chain word handshake.
REQ-009 SHALL have ports rd_valid_o  out  1, rd_data_o  out  WORD_W, and rd_ready_i  in  1, meaning the chain-to-host word handshake.
REQ-010 SHALL have ports scan_enable_o  out  1, scan_in_o  out  1, and scan_out_i  in  1, meaning the chain shift controls.
REQ-011 SHALL have port proc_en_o  out  1  meaning processor enable.
REQ-012 SHALL have ports busy_o, done_o, aborted_o, and err_o, each  out  1, meaning status.

Function
REQ-013 SHALL implement the states IDLE, LOAD, SHIFT, UNLOAD and FINISH.
REQ-014 SHALL go from IDLE to LOAD when start_i=1 and proc_req_i=0.
- Word counter: cleared to 0.
REQ-015 SHALL, if start_i=1 while not in IDLE or while proc_req_i=1, ignore the start and set err_o sticky until reset.
REQ-016 SHALL, in LOAD, assert wr_ready_o.
- On wr_valid_i&wr_ready_o: shreg <= wr_data_i, bit counter <= WORD_W-1, next state SHIFT.
REQ-017 SHALL, in SHIFT, drive scan_enable_o=1 and scan_in_o=shreg[WORD_W-1] for exactly WORD_W consecutive cycles.
- Each of those cycles: shreg <= {shreg[WORD_W-2:0], scan_out_i}.
- scan_out_i is sampled in the same cycle as its enable.
REQ-018 SHALL drive scan_enable_o=0 in every state other than SHIFT.
REQ-019 SHALL go from SHIFT to UNLOAD when the bit counter is 0.
REQ-020 SHALL, in UNLOAD, assert rd_valid_o with rd_data_o=shreg.
- rd_data_o is held stable until rd_ready_i.
- On the handshake: word counter +1; next state LOAD, or FINISH if the counter was CHAIN_LEN/WORD_W-1.
REQ-021 SHALL pulse done_o for one cycle in FINISH and then return to IDLE.
REQ-022 SHALL, on abort_i=1 in any non-IDLE state, go to IDLE on the next edge.
- Also: scan_enable_o=0 from that edge, counters cleared, aborted_o pulsed once, done_o not pulsed.
- abort_i takes priority over every other event that cycle.
REQ-023 SHALL drive busy_o=1 in every state other than IDLE.
REQ-024 SHALL drive proc_en_o = proc_req_i AND (state==IDLE), registered, so it follows proc_req_i with one cycle of latency.
REQ-025 SHALL never assert proc_en_o and scan_enable_o in the same cycle.
REQ-026 SHALL, if start_i and proc_req_i rise in the same cycle, give the start no effect, set err_o, and let proc_en_o follow proc_req_i.

Reset
REQ-027 SHALL, while wb_rst_n=0, asynchronously force state IDLE, counters 0, shreg 0, and every output 0.
REQ-028 SHALL, on reset in mid-pass, abandon the pass, drop scan_enable_o immediately, and pulse neither done_o nor aborted_o.

Structure
REQ-029 SHALL place the state encoding enum and the default WORD_W/CHAIN_LEN constants in the shared package qtcore_pkg.
REQ-030 SHALL use a single sub-module scan_shift_reg, holding shreg, the bit counter and the serial I/O; the FSM stays in the top module.

Verification
REQ-031 SHALL cover a full pass with CHAIN_LEN=64 and a loopback model of a 64-bit chain preloaded with 0xA5A5A5A5_5A5A5A5A:
- Stimulus: write words 0x12345678, then 0x9ABCDEF0.
- Required: rd words 0xA5A5A5A5 then 0x5A5A5A5A; chain holds 0x123456789ABCDEF0; done_o pulses once.
REQ-032 SHALL cover enable timing: scan_enable_o is high for exactly 32 cycles per word, and 0 while rd_valid_o waits 10 cycles for rd_ready_i.
REQ-033 SHALL cover the interlock:
- proc_req_i=1 then start_i -> err_o=1, state stays IDLE, proc_en_o=1 one cycle after proc_req_i.
- proc_req_i raised mid-pass -> proc_en_o stays 0 until after done_o.
REQ-034 SHALL cover abort_i at bit 17 of word 0 -> scan_enable_o=0 next cycle, aborted_o pulses once, busy_o=0, done_o never asserts.
REQ-035 SHALL cover reset: wb_rst_n low during SHIFT -> all outputs 0 immediately; a subsequent start runs a clean full pass.
